// File: rtl/arc4_pkg.sv
`default_nettype none
// ============================================================================
// Module : arc4_pkg
// Brief  : Shared types and constants for the ARC4 sequencer slice.
// Rev    : 1.0  initial release
// ============================================================================
package arc4_pkg;

    localparam int ARC4_KEY_W  = 24;
    localparam int ARC4_ADDR_W = 8;

    localparam logic [1:0] PH_IDLE = 2'd0;
    localparam logic [1:0] PH_INIT = 2'd1;
    localparam logic [1:0] PH_KSA  = 2'd2;
    localparam logic [1:0] PH_PRGA = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_INIT_GO   = 4'd1,
        S_INIT_BUSY = 4'd2,
        S_INIT_END  = 4'd3,
        S_KSA_GO    = 4'd4,
        S_KSA_BUSY  = 4'd5,
        S_KSA_END   = 4'd6,
        S_PRGA_GO   = 4'd7,
        S_PRGA_BUSY = 4'd8,
        S_PRGA_END  = 4'd9
    } seq_state_t;

    function automatic logic [1:0] state_phase(input seq_state_t s);
        case (s)
            S_INIT_GO, S_INIT_BUSY, S_INIT_END: state_phase = PH_INIT;
            S_KSA_GO,  S_KSA_BUSY,  S_KSA_END:  state_phase = PH_KSA;
            S_PRGA_GO, S_PRGA_BUSY, S_PRGA_END: state_phase = PH_PRGA;
            default:                            state_phase = PH_IDLE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/arc4_seq_s_port_mux.sv
`default_nettype none
// ============================================================================
// Module : s_port_mux
// Brief  : Combinational 3:1 S-memory port mux selected by the active phase.
// Rev    : 1.0  initial release
// ============================================================================
module s_port_mux
    import arc4_pkg::*;
#(
    parameter int ADDR_W = ARC4_ADDR_W
) (
    input  logic [1:0]        phase,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [7:0]        init_wrdata,
    input  logic              init_wren,
    input  logic [ADDR_W-1:0] ksa_addr,
    input  logic [7:0]        ksa_wrdata,
    input  logic              ksa_wren,
    input  logic [ADDR_W-1:0] prga_addr,
    input  logic [7:0]        prga_wrdata,
    input  logic              prga_wren,
    output logic [ADDR_W-1:0] s_addr,
    output logic [7:0]        s_wrdata,
    output logic              s_wren
);

    always_comb begin
        s_addr   = '0;
        s_wrdata = '0;
        s_wren   = 1'b0;
        case (phase)
            PH_INIT: begin
                s_addr   = init_addr;
                s_wrdata = init_wrdata;
                s_wren   = init_wren;
            end
            PH_KSA: begin
                s_addr   = ksa_addr;
                s_wrdata = ksa_wrdata;
                s_wren   = ksa_wren;
            end
            PH_PRGA: begin
                s_addr   = prga_addr;
                s_wrdata = prga_wrdata;
                s_wren   = prga_wren;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/arc4_seq.sv
`default_nettype none
// ============================================================================
// Module : arc4_seq
// Brief  : Runs init, ksa and prga in order and hands each the S-memory port.
// Rev    : 1.0  initial release
// ============================================================================
module arc4_seq
    import arc4_pkg::*;
#(
    parameter int KEY_W  = ARC4_KEY_W,
    parameter int ADDR_W = ARC4_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic              rdy,
    input  logic [KEY_W-1:0]  key,
    output logic [1:0]        phase,
    output logic              init_en,
    input  logic              init_rdy,
    output logic              ksa_en,
    input  logic              ksa_rdy,
    output logic [KEY_W-1:0]  ksa_key,
    output logic              prga_en,
    input  logic              prga_rdy,
    output logic [KEY_W-1:0]  prga_key,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [7:0]        init_wrdata,
    input  logic              init_wren,
    input  logic [ADDR_W-1:0] ksa_addr,
    input  logic [7:0]        ksa_wrdata,
    input  logic              ksa_wren,
    input  logic [ADDR_W-1:0] prga_addr,
    input  logic [7:0]        prga_wrdata,
    input  logic              prga_wren,
    output logic [ADDR_W-1:0] s_addr,
    output logic [7:0]        s_wrdata,
    output logic              s_wren
);

    seq_state_t       state_q, state_d;
    logic [KEY_W-1:0] key_q,   key_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
        end
    end

    // Each engine enable mirrors its rdy only in GO, so it fires exactly once.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        rdy     = 1'b0;
        init_en = 1'b0;
        ksa_en  = 1'b0;
        prga_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                rdy = 1'b1;
                if (en) begin
                    key_d   = key;
                    state_d = S_INIT_GO;
                end
            end
            S_INIT_GO: begin
                init_en = init_rdy;
                if (init_rdy) state_d = S_INIT_BUSY;
            end
            S_INIT_BUSY: if (!init_rdy) state_d = S_INIT_END;
            S_INIT_END:  if (init_rdy)  state_d = S_KSA_GO;
            S_KSA_GO: begin
                ksa_en = ksa_rdy;
                if (ksa_rdy) state_d = S_KSA_BUSY;
            end
            S_KSA_BUSY:  if (!ksa_rdy)  state_d = S_KSA_END;
            S_KSA_END:   if (ksa_rdy)   state_d = S_PRGA_GO;
            S_PRGA_GO: begin
                prga_en = prga_rdy;
                if (prga_rdy) state_d = S_PRGA_BUSY;
            end
            S_PRGA_BUSY: if (!prga_rdy) state_d = S_PRGA_END;
            S_PRGA_END:  if (prga_rdy)  state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    assign phase    = state_phase(state_q);
    assign ksa_key  = key_q;
    assign prga_key = key_q;

    s_port_mux #(
        .ADDR_W (ADDR_W)
    ) u_s_port_mux (
        .phase       (phase),
        .init_addr   (init_addr),
        .init_wrdata (init_wrdata),
        .init_wren   (init_wren),
        .ksa_addr    (ksa_addr),
        .ksa_wrdata  (ksa_wrdata),
        .ksa_wren    (ksa_wren),
        .prga_addr   (prga_addr),
        .prga_wrdata (prga_wrdata),
        .prga_wren   (prga_wren),
        .s_addr      (s_addr),
        .s_wrdata    (s_wrdata),
        .s_wren      (s_wren)
    );

endmodule
`default_nettype wire

// File: tb/tb_arc4_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_arc4_seq
// Brief  : Directed bench for arc4_seq with fixed-latency stub engines.
// Rev    : 1.0  initial release
// ============================================================================
module tb_arc4_seq;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        rdy;
    logic [23:0] key;
    logic [1:0]  phase;
    logic        init_en, init_rdy, ksa_en, ksa_rdy, prga_en, prga_rdy;
    logic [23:0] ksa_key, prga_key;
    logic [7:0]  init_addr, ksa_addr, prga_addr;
    logic [7:0]  init_wrdata, ksa_wrdata, prga_wrdata;
    logic        init_wren, ksa_wren, prga_wren;
    logic [7:0]  s_addr, s_wrdata;
    logic        s_wren;

    int n_cmp = 0;
    int n_err = 0;

    int  ni, nk, np;
    int  icnt, kcnt, pcnt;
    logic hold_init;
    logic wren_all;

    int cyc = 0;
    int n_init = 0, n_ksa = 0, n_prga = 0;
    int t_init = 0, t_ksa = 0, t_prga = 0;
    int n_ph1 = 0, n_ph3 = 0;
    int mux_err = 0;

    arc4_seq #(
        .KEY_W  (24),
        .ADDR_W (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .rdy         (rdy),
        .key         (key),
        .phase       (phase),
        .init_en     (init_en),
        .init_rdy    (init_rdy),
        .ksa_en      (ksa_en),
        .ksa_rdy     (ksa_rdy),
        .ksa_key     (ksa_key),
        .prga_en     (prga_en),
        .prga_rdy    (prga_rdy),
        .prga_key    (prga_key),
        .init_addr   (init_addr),
        .init_wrdata (init_wrdata),
        .init_wren   (init_wren),
        .ksa_addr    (ksa_addr),
        .ksa_wrdata  (ksa_wrdata),
        .ksa_wren    (ksa_wren),
        .prga_addr   (prga_addr),
        .prga_wrdata (prga_wrdata),
        .prga_wren   (prga_wren),
        .s_addr      (s_addr),
        .s_wrdata    (s_wrdata),
        .s_wren      (s_wren)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stub engines: rdy drops the edge after en and stays low for N cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            icnt <= 0; kcnt <= 0; pcnt <= 0;
        end else begin
            if (init_en && init_rdy) icnt <= ni; else if (icnt > 0) icnt <= icnt - 1;
            if (ksa_en  && ksa_rdy)  kcnt <= nk; else if (kcnt > 0) kcnt <= kcnt - 1;
            if (prga_en && prga_rdy) pcnt <= np; else if (pcnt > 0) pcnt <= pcnt - 1;
        end
    end

    assign init_rdy    = (icnt == 0) && !hold_init;
    assign ksa_rdy     = (kcnt == 0);
    assign prga_rdy    = (pcnt == 0);
    assign init_addr   = 8'h11;
    assign ksa_addr    = 8'h22;
    assign prga_addr   = 8'h33;
    assign init_wrdata = 8'hA1;
    assign ksa_wrdata  = 8'hA2;
    assign prga_wrdata = 8'hA3;
    assign init_wren   = wren_all;
    assign ksa_wren    = wren_all;
    assign prga_wren   = wren_all;

    always @(negedge clk) begin
        if (init_en === 1'b1) begin n_init++; t_init = cyc; end
        if (ksa_en  === 1'b1) begin n_ksa++;  t_ksa  = cyc; end
        if (prga_en === 1'b1) begin n_prga++; t_prga = cyc; end
        case (phase)
            2'd0: if (s_wren !== 1'b0 || s_addr !== 8'h00 || s_wrdata !== 8'h00) mux_err++;
            2'd1: if (s_wren !== wren_all || s_addr !== 8'h11 || s_wrdata !== 8'hA1) mux_err++;
            2'd2: if (s_wren !== wren_all || s_addr !== 8'h22 || s_wrdata !== 8'hA2) mux_err++;
            2'd3: if (s_wren !== wren_all || s_addr !== 8'h33 || s_wrdata !== 8'hA3) mux_err++;
            default: mux_err++;
        endcase
        if (phase === 2'd1) n_ph1++;
        if (phase === 2'd3) n_ph3++;
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Counts negedges since the acceptance cycle until rdy is seen high.
    task automatic wait_rdy(input int start, output int n);
        n = start;
        while (rdy !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
    endtask

    int n, w;
    int b_i, b_k, b_p, b_m, b_ph1, b_ph3;

    initial begin
        rst_n = 1'b0; en = 1'b0; key = '0;
        hold_init = 1'b0; wren_all = 1'b0;
        ni = 256; nk = 768; np = 40;
        #1;
        check("reset_rdy",     32'(rdy),     32'd1);
        check("reset_phase",   32'(phase),   32'd0);
        check("reset_enables", 32'({init_en, ksa_en, prga_en}), 32'd0);
        check("reset_s_wren",  32'(s_wren),  32'd0);
        check("reset_key",     32'(ksa_key), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Long sequence with the reference latencies
        b_i = n_init; b_k = n_ksa; b_p = n_prga;
        key = 24'h000018; en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        check("accept_rdy",   32'(rdy),   32'd0);
        check("accept_phase", 32'(phase), 32'd1);
        check("accept_key",   32'(ksa_key), 32'h000018);
        wait_rdy(1, n);
        check("long_latency", 32'(n), 32'd1071);
        check("init_pulses",  32'(n_init - b_i), 32'd1);
        check("ksa_pulses",   32'(n_ksa - b_k),  32'd1);
        check("prga_pulses",  32'(n_prga - b_p), 32'd1);
        check("pulse_order",  32'((t_init < t_ksa) && (t_ksa < t_prga)), 32'd1);
        check("ksa_key",      32'(ksa_key),  32'h000018);
        check("prga_key",     32'(prga_key), 32'h000018);

        // Memory ownership with every engine writing
        ni = 3; nk = 4; np = 5;
        wren_all = 1'b1;
        @(negedge clk);
        check("idle_s_wren", 32'(s_wren), 32'd0);
        check("idle_s_addr", 32'(s_addr), 32'd0);
        b_m = mux_err; b_ph1 = n_ph1; b_ph3 = n_ph3;
        key = 24'h123456; en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        check("init_owner_addr", 32'(s_addr), 32'h11);
        wait_rdy(1, n);
        check("short_latency", 32'(n), 32'd19);
        check("mux_errors",    32'(mux_err - b_m), 32'd0);
        check("init_cycles",   32'(n_ph1 - b_ph1), 32'd5);
        check("prga_cycles",   32'(n_ph3 - b_ph3), 32'd7);
        wren_all = 1'b0;

        // init_rdy held low in INIT_GO for 5 cycles
        b_i = n_init;
        hold_init = 1'b1;
        key = 24'h00ABCD; en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall_init_en_low", 32'(init_en), 32'd0);
            @(negedge clk);
        end
        hold_init = 1'b0;
        #1;
        check("stall_init_en_high", 32'(init_en), 32'd1);
        @(negedge clk);
        check("stall_init_en_drop", 32'(init_en), 32'd0);
        check("stall_phase",        32'(phase),   32'd1);
        wait_rdy(7, n);
        check("stall_latency",     32'(n), 32'd24);
        check("stall_init_pulses", 32'(n_init - b_i), 32'd1);

        // en during KSA_BUSY is ignored
        b_i = n_init;
        key = 24'h0A0B0C; en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        w = 1;
        while (ksa_en !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("ksa_go_reached", 32'(w), 32'd6);
        @(negedge clk);
        w++;
        key = 24'hFFFFFF; en = 1'b1;
        @(negedge clk);
        w++;
        en = 1'b0;
        check("busy_en_key", 32'(ksa_key), 32'h0A0B0C);
        wait_rdy(w, n);
        check("busy_en_latency", 32'(n), 32'd19);
        check("busy_en_prga_key", 32'(prga_key), 32'h0A0B0C);
        @(negedge clk); @(negedge clk); @(negedge clk);
        check("busy_en_still_idle", 32'(rdy), 32'd1);
        check("busy_en_one_seq",    32'(n_init - b_i), 32'd1);

        // Asynchronous reset in the middle of PRGA
        np = 40;
        wren_all = 1'b1;
        key = 24'h55AA55; en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        w = 0;
        while (phase !== 2'd3 && w < 100) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk); @(negedge clk); @(negedge clk);
        check("prga_s_wren", 32'(s_wren), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_rdy",    32'(rdy),     32'd1);
        check("arst_phase",  32'(phase),   32'd0);
        check("arst_s_wren", 32'(s_wren),  32'd0);
        check("arst_prga_en",32'(prga_en), 32'd0);
        check("arst_key",    32'(ksa_key), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wren_all = 1'b0;
        @(negedge clk);
        key = 24'h000777; en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        wait_rdy(1, n);
        check("post_rst_latency", 32'(n), 32'd54);
        check("post_rst_key",     32'(ksa_key), 32'h000777);

        // en held high: back-to-back acceptance in the first IDLE cycle
        np = 5;
        key = 24'h0C0FFE; en = 1'b1;
        @(negedge clk);
        key = 24'h0BEEF0;
        wait_rdy(1, n);
        check("b2b_first_latency", 32'(n), 32'd19);
        check("b2b_first_key",     32'(ksa_key), 32'h0C0FFE);
        @(negedge clk);
        en = 1'b0;
        check("b2b_rdy",   32'(rdy),     32'd0);
        check("b2b_phase", 32'(phase),   32'd1);
        check("b2b_key",   32'(ksa_key), 32'h0BEEF0);
        wait_rdy(1, n);
        check("b2b_second_latency", 32'(n), 32'd19);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
